sr_latch_writer: RTL and testbench
==================================

Name: sr_latch_writer

Overview:
Clocked driver for an external cross-coupled NOR set/reset latch. It accepts a one-bit write request over a valid/ready handshake and generates a non-overlapping set or reset pulse of programmable width. It then reads back the latch's Q/Qn through a synchronizer and reports completion, or timeout, on a one-cycle done strobe. It sits between synchronous control logic and the asynchronous storage cell, and also flags an illegal Q==Qn state while idle.

Parameters:
PULSE_CYCLES, 2, width of set/reset pulse in clocks (>=1)
TIMEOUT_CYCLES, 8, clocks allowed in SETTLE for readback to match (>=1)
SYNC_STAGES, 2, flop depth of Q/Qn readback synchronizer (>=2)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  write request present
req_value  input  1  value to store (1 = set, 0 = reset)
req_ready  output  1  high only in IDLE; request accepted on edge where req_valid & req_ready
latch_set  output  1  registered drive to latch Set input
latch_reset  output  1  registered drive to latch Reset input
latch_q  input  1  latch Q, asynchronous to clk
latch_qn  input  1  latch Qn, asynchronous to clk
done_valid  output  1  one-cycle completion strobe
done_error  output  1  qualifies done_valid: 1 = readback timeout
err_forbidden  output  1  sticky: Q==Qn seen while IDLE

Behaviour:
- Reset (async assert): state IDLE; latch_set=0, latch_reset=0, done_valid=0, done_error=0, err_forbidden=0, req_ready=1; synchronizer flops and counters cleared. Reset mid-pulse drops the drive immediately and produces no done strobe.
- States: IDLE, PULSE, SETTLE, DONE. req_ready = (state==IDLE).
- IDLE -> PULSE on accept.
  - Capture req_value into val_r.
  - Load pulse counter with PULSE_CYCLES-1.
  - Register latch_set=val_r and latch_reset=~val_r.
  - Clear err_forbidden.
- PULSE: hold drive. On an edge with counter==0: deassert both drives, load timer with TIMEOUT_CYCLES-1, go SETTLE. Otherwise decrement.
- SETTLE: both drives 0. Match = (q_s==val_r) & (qn_s==~val_r), using synchronized values.
  - Match -> DONE with done_error=0.
  - Else, timer==0 -> DONE with done_error=1.
  - Else decrement timer.
- DONE: done_valid=1 for exactly one cycle, done_error valid with it. Next edge -> IDLE, and done_valid/done_error return to 0.
- latch_set and latch_reset are never 1 simultaneously, including across reset and every transition. Both are 0 in IDLE, SETTLE and DONE.
- Requests while busy are ignored (ready=0). req_value is sampled only on the accept edge.
- A write of the value already stored still issues a full pulse and completes normally.
- err_forbidden: in IDLE, if q_s==qn_s on an edge, set to 1. It holds until the next accept. It does not block requests.
- Latency with defaults and a combinationally responding latch:
  - Accept at edge E0; drive high after E0 and E1, low after E2.
  - DONE entered at E3; done_valid high in the cycle after E3.
  - A never-matching readback enters DONE at E10 with done_error=1.

Decomposition:
- Shared package sr_latch_pkg:
  - state enum type (IDLE/PULSE/SETTLE/DONE)
  - counter width function clog2-based
  - parameter legality assertions
- One sub-module: bit_synchronizer (SYNC_STAGES flops, async reset to 0), instantiated twice for latch_q and latch_qn.

Test Plan:
- Reset release, idle 5 cycles -> req_ready=1, latch_set=latch_reset=0, done_valid=0, err_forbidden=0.
- Latch model holding 0; req_value=1 accepted at E0 -> latch_set high exactly 2 cycles, latch_reset stays 0, done_valid=1 with done_error=0 after E3, req_ready=1 after E4.
- Latch model stuck at Q=0, Qn=1; req_value=1 -> done_valid=1, done_error=1 after E10; drives 0 throughout SETTLE.
- req_valid held high with alternating values during a busy operation -> only the accept-edge value is driven; no second pulse until after DONE; set and reset never both 1.
- Latch model outputs Q=Qn=0 while idle -> err_forbidden=1 within SYNC_STAGES+1 edges, stays 1; next accepted request clears it.
- rst_n asserted during PULSE (cycle after E0) -> latch_set drops to 0 asynchronously, no done strobe; after release req_ready=1 and a new request completes normally.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// Shared types and helpers for the SR latch writer.
`timescale 1ns/1ps
package sr_latch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PULSE  = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Bits needed to hold the values 0 .. n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Legal parameter ranges for the writer.
   function automatic bit params_legal(input int pulse_cycles,
                                       input int timeout_cycles,
                                       input int sync_stages);
      return (pulse_cycles >= 1) && (timeout_cycles >= 1) && (sync_stages >= 2);
   endfunction

endpackage

// File: rtl/sr_latch_writer_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
`timescale 1ns/1ps
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_r;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/sr_latch_writer.sv
// Clocked set/reset pulse driver for an external NOR latch with readback.
`timescale 1ns/1ps
module sr_latch_writer #(
   parameter int PULSE_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 8,
   parameter int SYNC_STAGES    = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   input  logic req_value,
   output logic req_ready,
   output logic latch_set,
   output logic latch_reset,
   input  logic latch_q,
   input  logic latch_qn,
   output logic done_valid,
   output logic done_error,
   output logic err_forbidden
);
   import sr_latch_pkg::*;

   localparam int PW = cnt_width(PULSE_CYCLES);
   localparam int TW = cnt_width(TIMEOUT_CYCLES);
   localparam int SW = cnt_width(SYNC_STAGES + 1);

   localparam logic [PW-1:0] PULSE_LOAD   = PW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] PRIME_DONE   = SW'(SYNC_STAGES);

   if (!params_legal(PULSE_CYCLES, TIMEOUT_CYCLES, SYNC_STAGES)) begin : g_bad_params
      $error("sr_latch_writer: illegal PULSE_CYCLES/TIMEOUT_CYCLES/SYNC_STAGES");
   end

   state_t          state;
   logic            val_r;
   logic [PW-1:0]   pulse_cnt;
   logic [TW-1:0]   timer;
   logic [SW-1:0]   prime_cnt;
   logic            q_s;
   logic            qn_s;
   logic            primed;
   logic            match;

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_q (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (latch_q),
      .q     (q_s)
   );

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_qn (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (latch_qn),
      .q     (qn_s)
   );

   // Both synchronizer chains reset to 0, which reads as Q==Qn until real
   // samples have propagated; the forbidden-state check waits for that.
   assign primed    = (prime_cnt == PRIME_DONE);
   assign match     = (q_s == val_r) && (qn_s == ~val_r);
   assign req_ready = (state == IDLE);

   // Write sequencer: accept, pulse, wait for readback, strobe completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         val_r         <= 1'b0;
         pulse_cnt     <= '0;
         timer         <= '0;
         prime_cnt     <= '0;
         latch_set     <= 1'b0;
         latch_reset   <= 1'b0;
         done_valid    <= 1'b0;
         done_error    <= 1'b0;
         err_forbidden <= 1'b0;
      end else begin
         done_valid <= 1'b0;
         done_error <= 1'b0;
         if (!primed) begin
            prime_cnt <= prime_cnt + SW'(1);
         end
         case (state)
            IDLE: begin
               if (req_valid) begin
                  val_r         <= req_value;
                  pulse_cnt     <= PULSE_LOAD;
                  latch_set     <= req_value;
                  latch_reset   <= ~req_value;
                  err_forbidden <= 1'b0;
                  state         <= PULSE;
               end else if (primed && (q_s == qn_s)) begin
                  err_forbidden <= 1'b1;
               end
            end
            PULSE: begin
               if (pulse_cnt == '0) begin
                  latch_set   <= 1'b0;
                  latch_reset <= 1'b0;
                  timer       <= TIMEOUT_LOAD;
                  state       <= SETTLE;
               end else begin
                  pulse_cnt <= pulse_cnt - PW'(1);
               end
            end
            SETTLE: begin
               if (match) begin
                  done_valid <= 1'b1;
                  state      <= DONE;
               end else if (timer == '0) begin
                  done_valid <= 1'b1;
                  done_error <= 1'b1;
                  state      <= DONE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               latch_set   <= 1'b0;
               latch_reset <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_writer.sv
// Directed self-checking bench for sr_latch_writer with a behavioural latch.
`timescale 1ns/1ps
module tb_sr_latch_writer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid = 1'b0;
   logic req_value = 1'b0;
   logic req_ready;
   logic latch_set;
   logic latch_reset;
   logic latch_q;
   logic latch_qn;
   logic done_valid;
   logic done_error;
   logic err_forbidden;

   // Latch model: normal NOR-latch behaviour, or forced Q/Qn values.
   logic stored = 1'b0;
   logic forced = 1'b0;
   logic fq     = 1'b0;
   logic fqn    = 1'b1;

   int checks   = 0;
   int failures = 0;
   int overlap_cnt = 0;
   int done_cnt    = 0;

   sr_latch_writer #(
      .PULSE_CYCLES   (2),
      .TIMEOUT_CYCLES (8),
      .SYNC_STAGES    (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_value     (req_value),
      .req_ready     (req_ready),
      .latch_set     (latch_set),
      .latch_reset   (latch_reset),
      .latch_q       (latch_q),
      .latch_qn      (latch_qn),
      .done_valid    (done_valid),
      .done_error    (done_error),
      .err_forbidden (err_forbidden)
   );

   always #5 clk = ~clk;

   // Storage cell reacts immediately to its drive inputs.
   always @(latch_set or latch_reset) begin
      if (latch_set) stored = 1'b1;
      else if (latch_reset) stored = 1'b0;
   end

   assign latch_q  = forced ? fq  : stored;
   assign latch_qn = forced ? fqn : ~stored;

   // Track drive overlap and done strobes across the whole run.
   always @(negedge clk) begin
      if (latch_set && latch_reset) overlap_cnt++;
      if (done_valid) done_cnt++;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // One write; k counts edges after the accept edge E0.
   task automatic do_write(input logic v, output int done_edge, output int err,
                           output int set_cyc, output int rst_cyc, output int ef0);
      @(negedge clk);
      check("ready_before_write", req_ready, 1);
      req_valid = 1'b1;
      req_value = v;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      done_edge = -1;
      err       = -1;
      set_cyc   = 0;
      rst_cyc   = 0;
      ef0       = err_forbidden;
      for (int k = 0; k < 30; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         set_cyc += int'(latch_set);
         rst_cyc += int'(latch_reset);
         if (done_valid) begin
            done_edge = k;
            err       = done_error;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic value;
      logic force_en;
      logic fq;
      logic fqn;
      int   exp_edge;
      int   exp_err;
      int   exp_set;
      int   exp_rst;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int de, er, sc, rc, ef, n, dbefore;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 3,  0, 2, 0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 3,  0, 2, 0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 3,  0, 0, 2};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 10, 1, 2, 0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 3,  0, 0, 2};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1, 0, 2};

      // Reset release and idle.
      idle(3);
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);
      check("rst_req_ready",     req_ready,     1);
      check("rst_latch_set",     latch_set,     0);
      check("rst_latch_reset",   latch_reset,   0);
      check("rst_done_valid",    done_valid,    0);
      check("rst_err_forbidden", err_forbidden, 0);

      // Table-driven writes.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         forced = vecs[i].force_en;
         fq     = vecs[i].fq;
         fqn    = vecs[i].fqn;
         idle(4);
         do_write(vecs[i].value, de, er, sc, rc, ef);
         check($sformatf("v%0d_done_edge", i), de, vecs[i].exp_edge);
         check($sformatf("v%0d_done_error", i), er, vecs[i].exp_err);
         check($sformatf("v%0d_set_cycles", i), sc, vecs[i].exp_set);
         check($sformatf("v%0d_reset_cycles", i), rc, vecs[i].exp_rst);
         check($sformatf("v%0d_ready_after", i), req_ready, 1);
         check($sformatf("v%0d_no_forbidden", i), err_forbidden, 0);
      end

      @(negedge clk);
      forced = 1'b0;
      idle(4);

      // Busy: req_valid held high with toggling value during the write.
      @(negedge clk);
      req_valid = 1'b1;
      req_value = 1'b1;
      @(posedge clk);
      sc = 0; rc = 0; de = -1;
      for (int k = 0; k < 30; k++) begin
         if (k > 0) @(posedge clk);
         #1;
         sc += int'(latch_set);
         rc += int'(latch_reset);
         if (done_valid) begin
            de = k;
            break;
         end
         req_value = ~req_value;
      end
      req_valid = 1'b0;
      check("busy_done_edge",    de, 3);
      check("busy_set_cycles",   sc, 2);
      check("busy_reset_cycles", rc, 0);
      sc = 0; rc = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         sc += int'(latch_set);
         rc += int'(latch_reset);
      end
      check("busy_no_second_pulse", sc + rc, 0);
      check("busy_ready_after",     req_ready, 1);

      // Forbidden Q==Qn while idle.
      @(negedge clk);
      forced = 1'b1;
      fq     = 1'b0;
      fqn    = 1'b0;
      n = -1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (err_forbidden) begin
            n = k;
            break;
         end
      end
      check("forbid_latency", n, 3);
      idle(4);
      check("forbid_sticky",       err_forbidden, 1);
      check("forbid_ready_intact", req_ready,     1);
      @(negedge clk);
      fqn = 1'b1;
      idle(4);
      check("forbid_sticky_after_fix", err_forbidden, 1);
      do_write(1'b0, de, er, sc, rc, ef);
      check("forbid_cleared_on_accept", ef, 0);
      check("forbid_write_done_edge",   de, 3);
      check("forbid_write_error",       er, 0);
      check("forbid_stays_clear",       err_forbidden, 0);
      @(negedge clk);
      forced = 1'b0;
      idle(4);

      // Reset during PULSE.
      @(negedge clk);
      req_valid = 1'b1;
      req_value = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("midrst_set_before", latch_set, 1);
      dbefore = done_cnt;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_set_dropped",   latch_set,   0);
      check("midrst_reset_low",     latch_reset, 0);
      check("midrst_ready_in_rst",  req_ready,   1);
      idle(3);
      @(negedge clk);
      rst_n = 1'b1;
      idle(6);
      check("midrst_no_done",      done_cnt, dbefore);
      check("midrst_ready_after",  req_ready, 1);
      check("midrst_no_forbidden", err_forbidden, 0);
      do_write(1'b0, de, er, sc, rc, ef);
      check("midrst_rewrite_done_edge", de, 3);
      check("midrst_rewrite_error",     er, 0);
      check("midrst_rewrite_reset_cyc", rc, 2);
      check("midrst_rewrite_set_cyc",   sc, 0);

      check("no_drive_overlap", overlap_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
